// File: rtl/coincidence_csr_pkg.sv
// CSR bit layout shared with the coincidence recorder, plus the reader's
// state encoding and width helpers.
package coincidence_csr_pkg;

    localparam int START_BIT   = 31;
    localparam int COINC_BIT   = 30;
    localparam int REALIGN_BIT = 29;
    localparam int MUX_LSB     = 24;
    localparam int BUSY_BIT    = 31;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ARM     = 3'd1;
    localparam state_t S_WAIT_HI = 3'd2;
    localparam state_t S_WAIT_LO = 3'd3;
    localparam state_t S_SET     = 3'd4;
    localparam state_t S_SETTLE  = 3'd5;
    localparam state_t S_MATCH   = 3'd6;
    localparam state_t S_EMIT    = 3'd7;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int field_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bin_width(input int channels, input int samples, input int sum_width);
        return field_width(channels) + field_width(samples) + sum_width;
    endfunction

endpackage

// File: rtl/reader_timeout.sv
// Loadable down-counter shared by every bounded wait in the histogram reader.
// expire is high on the cycle the count sits at zero while the wait is active.
module reader_timeout #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/coincidence_histogram_reader.sv
// Arms a coincidence acquisition, waits for it to finish, then walks every
// (channel, address) bin through the recorder CSR and streams the counts out.
module coincidence_histogram_reader
    import coincidence_csr_pkg::*;
#(
    parameter int CHANNEL_COUNT               = 2,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 16,
    parameter int SUM_WIDTH                   = 8,
    parameter int SETTLE_CYCLES               = 8,
    parameter int TIMEOUT_CYCLES              = 2**20,
    localparam int MUXSEL_WIDTH = field_width(CHANNEL_COUNT),
    localparam int ADDR_WIDTH   = field_width(SAMPLE_CLKS_PER_COINCIDENCE),
    localparam int BIN_WIDTH    = bin_width(CHANNEL_COUNT, SAMPLE_CLKS_PER_COINCIDENCE, SUM_WIDTH)
) (
    input  logic                 sysClk,
    input  logic                 sysResetN,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 error,
    output logic                 csrStrobe,
    output logic [31:0]          csrData,
    input  logic [31:0]          csrStatus,
    output logic                 binValid,
    input  logic                 binReady,
    output logic [BIN_WIDTH-1:0] binData,
    output logic                 binLast,
    output state_t               state
);

    localparam int TIMER_MAX   = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TIMER_WIDTH = $clog2(TIMER_MAX + 1);

    localparam logic [MUXSEL_WIDTH-1:0] LAST_CHAN = MUXSEL_WIDTH'(CHANNEL_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(SAMPLE_CLKS_PER_COINCIDENCE - 1);

    state_t                  state_next;
    logic [MUXSEL_WIDTH-1:0] chan;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [SUM_WIDTH-1:0]    count;
    logic [31:0]             csr_word;
    logic [31:0]             csr_hold;
    logic [TIMER_WIDTH-1:0]  timer_load;
    logic                    timeout_hit;
    logic                    expire;
    logic                    in_wait;
    logic                    echo_match;
    logic                    last_bin;
    logic                    unused_status;

    assign in_wait    = (state == S_WAIT_HI) || (state == S_WAIT_LO) ||
                        (state == S_SETTLE)  || (state == S_MATCH);
    assign echo_match = (csrStatus[MUX_LSB +: MUXSEL_WIDTH] == chan) &&
                        (csrStatus[SUM_WIDTH +: ADDR_WIDTH] == addr);
    assign last_bin   = (chan == LAST_CHAN) && (addr == LAST_ADDR);

    // The timer reloads on every state change, so each wait starts fresh;
    // SETTLE borrows it as a fixed delay.
    assign timer_load = (state_next == S_SETTLE) ? TIMER_WIDTH'(SETTLE_CYCLES - 1)
                                                 : TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    reader_timeout #(
        .WIDTH (TIMER_WIDTH)
    ) u_timeout (
        .clk        (sysClk),
        .reset_n    (sysResetN),
        .load       (state_next != state),
        .load_value (timer_load),
        .enable     (in_wait),
        .expire     (expire)
    );

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:    if (start) state_next = S_ARM;
            S_ARM:     state_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (csrStatus[BUSY_BIT]) state_next = S_WAIT_LO;
                else if (expire) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!csrStatus[BUSY_BIT]) state_next = S_SET;
                else if (expire) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_SET:     state_next = S_SETTLE;
            S_SETTLE:  if (expire) state_next = S_MATCH;
            S_MATCH: begin
                if (echo_match) state_next = S_EMIT;
                else if (expire) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_EMIT:    if (binReady) state_next = last_bin ? S_IDLE : S_SET;
            default:   state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next  = S_IDLE;
            timeout_hit = 1'b0;
        end
    end

    always_comb begin
        csr_word = '0;
        if (state == S_ARM) begin
            csr_word[START_BIT] = 1'b1;
        end else begin
            csr_word[MUX_LSB +: MUXSEL_WIDTH] = chan;
            csr_word[0 +: ADDR_WIDTH]         = addr;
            csr_word[START_BIT]               = 1'b0;
            csr_word[COINC_BIT]               = 1'b0;
            csr_word[REALIGN_BIT]             = 1'b0;
        end
    end

    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            state    <= S_IDLE;
            error    <= 1'b0;
            chan     <= '0;
            addr     <= '0;
            count    <= '0;
            csr_hold <= '0;
        end else begin
            state <= state_next;
            // The recorder's GPIO register keeps the last written word.
            if (csrStrobe) csr_hold <= csr_word;
            if ((state == S_IDLE) && (state_next == S_ARM)) begin
                error <= 1'b0;
                chan  <= '0;
                addr  <= '0;
            end
            if (timeout_hit) error <= 1'b1;
            if ((state == S_MATCH) && (state_next == S_EMIT)) count <= csrStatus[SUM_WIDTH-1:0];
            if ((state == S_EMIT) && (state_next == S_SET)) begin
                if (addr == LAST_ADDR) begin
                    addr <= '0;
                    chan <= chan + 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

    // Handshake: binData/binLast are stable while binValid && !binReady;
    // a word transfers on a clock edge where both are high.
    assign busy      = (state != S_IDLE);
    assign csrStrobe = (state == S_ARM) || (state == S_SET);
    assign csrData   = csrStrobe ? csr_word : csr_hold;
    assign binValid  = (state == S_EMIT);
    assign binData   = {chan, addr, count};
    assign binLast   = binValid && last_bin;

    assign unused_status = &{1'b0, csrStatus};

endmodule

// File: tb/tb_coincidence_histogram_reader.sv
// Bench for the histogram reader: recorder CSR model, table of acquisition runs
// checked against a bin-order scoreboard, and hand sequences for abort/reset.
module tb_coincidence_histogram_reader;
    import coincidence_csr_pkg::*;

    localparam int CH = 2;
    localparam int NS = 16;
    localparam int SW = 8;
    localparam int ST = 8;
    localparam int TO = 300;
    localparam int MW = 1;
    localparam int AW = 4;
    localparam int DW = MW + AW + SW;

    logic          sysClk = 1'b0;
    logic          sysResetN;
    logic          start;
    logic          abort;
    logic          busy;
    logic          error;
    logic          csrStrobe;
    logic [31:0]   csrData;
    logic [31:0]   csrStatus;
    logic          binValid;
    logic          binReady;
    logic [DW-1:0] binData;
    logic          binLast;
    state_t        state;

    coincidence_histogram_reader #(
        .CHANNEL_COUNT               (CH),
        .SAMPLE_CLKS_PER_COINCIDENCE (NS),
        .SUM_WIDTH                   (SW),
        .SETTLE_CYCLES               (ST),
        .TIMEOUT_CYCLES              (TO)
    ) dut (
        .sysClk    (sysClk),
        .sysResetN (sysResetN),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .error     (error),
        .csrStrobe (csrStrobe),
        .csrData   (csrData),
        .csrStatus (csrStatus),
        .binValid  (binValid),
        .binReady  (binReady),
        .binData   (binData),
        .binLast   (binLast),
        .state     (state)
    );

    always #5 sysClk = ~sysClk;

    // ---------------- recorder CSR model ----------------
    int          cyc = 0;
    int          busy_delay = 2;
    int          busy_len = 5;
    bit          no_busy = 1'b0;
    int          wrong_until = 0;
    int          acq_t = -1;
    logic [31:0] gpio = '0;
    logic [31:0] echo_pipe [4] = '{default: '0};
    logic [SW-1:0] cnt_mem [CH][NS];
    logic        acq_busy;
    logic        wrong_now;

    always @(posedge sysClk) begin
        if (csrStrobe === 1'b1) gpio <= csrData;
        echo_pipe[0] <= gpio;
        echo_pipe[1] <= echo_pipe[0];
        echo_pipe[2] <= echo_pipe[1];
        echo_pipe[3] <= echo_pipe[2];
        if ((csrStrobe === 1'b1) && csrData[31] && !no_busy) acq_t <= 0;
        else if ((acq_t >= 0) && (acq_t < 1000)) acq_t <= acq_t + 1;
    end

    assign acq_busy  = (acq_t >= busy_delay) && (acq_t < busy_delay + busy_len);
    assign wrong_now = (cyc < wrong_until);

    always_comb begin
        csrStatus            = '0;
        csrStatus[31]        = acq_busy;
        csrStatus[24]        = echo_pipe[3][24] ^ wrong_now;
        csrStatus[SW +: AW]  = echo_pipe[3][AW-1:0];
        csrStatus[SW-1:0]    = cnt_mem[echo_pipe[3][24]][echo_pipe[3][AW-1:0]];
    end

    // ---------------- scoreboard / bookkeeping ----------------
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int strobes, accepted, valid_seen, set_cyc, acc_cyc;
    bit acc_pending, hold_pending, prev_valid;
    logic [DW-1:0] held;

    typedef struct {
        int ready_pct;
        int stall_word;
        int stall_len;
        int rand_cnt;
        int bdelay;
        int blen;
        int nobusy;
        int wrong_len;
        int exp_words;
        int exp_strobes;
        int exp_error;
        int exp_busy_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        logic [31:0]   w;
        if (csrStrobe === 1'b1) begin
            strobes++;
            if (csrData[31] === 1'b0) begin
                set_cyc = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    w = '0;
                    w[24 +: MW] = e[DW-1 -: MW];
                    w[0 +: AW]  = e[SW +: AW];
                    check("set_word", csrData, w);
                end
                if (acc_pending) begin
                    check("set_after_accept", cyc - acc_cyc, 1);
                    acc_pending = 1'b0;
                end
            end else begin
                check("arm_word", csrData, 32'h8000_0000);
            end
        end
        if (hold_pending) begin
            check("hold_valid", binValid, 1'b1);
            check("hold_data", binData, held);
        end
        if ((binValid === 1'b1) && !prev_valid) begin
            valid_seen++;
            // SET cycle, SETTLE_CYCLES of settle, one MATCH cycle, then EMIT
            if ((set_cyc >= 0) && (set_cyc > wrong_until)) check("latency", cyc - set_cyc, 1 + ST + 1);
        end
        if ((binValid === 1'b1) && binReady && !abort) begin
            accepted++;
            acc_cyc = cyc;
            acc_pending = 1'b1;
            if (exp_q.size() == 0) begin
                check("extra_word", binData, '0);
                checks--;
                if (binData === '0) begin
                    failures++;
                    $display("FAIL extra_word: got %0h expected none", binData);
                end
            end else begin
                e = exp_q.pop_front();
                check("bin_data", binData, e);
                check("bin_last", binLast, exp_q.size() == 0);
            end
        end
        hold_pending = (binValid === 1'b1) && !binReady && !abort;
        held = binData;
        prev_valid = (binValid === 1'b1);
    endtask

    task automatic tick();
        @(negedge sysClk);
        monitor();
        @(posedge sysClk);
        cyc++;
        #1;
    endtask

    task automatic clear_stats();
        strobes = 0;
        accepted = 0;
        valid_seen = 0;
        set_cyc = -1;
        acc_pending = 1'b0;
    endtask

    // Reference: bins come out channel-major, address-minor, each with its stored count.
    task automatic load_reference(input int rand_cnt);
        logic [MW-1:0] cb;
        logic [AW-1:0] ab;
        exp_q.delete();
        for (int c = 0; c < CH; c++) begin
            for (int a = 0; a < NS; a++) begin
                cnt_mem[c][a] = rand_cnt ? SW'($urandom) : SW'(a + 16 * c);
                cb = MW'(c);
                ab = AW'(a);
                exp_q.push_back({cb, ab, cnt_mem[c][a]});
            end
        end
    endtask

    task automatic run_acq(input vec_t v);
        int n;
        int busy_cycles;
        int stall_left;
        bit stall_done;
        load_reference(v.rand_cnt);
        if (v.exp_error != 0) exp_q.delete();
        busy_delay = v.bdelay;
        busy_len = v.blen;
        no_busy = (v.nobusy != 0);
        clear_stats();
        stall_left = 0;
        stall_done = 1'b0;
        busy_cycles = 0;
        binReady = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wrong_until = cyc + v.wrong_len;
        check("start_busy", busy, 1'b1);
        check("start_error_clear", error, 1'b0);
        n = 0;
        while (busy && (n < 4000)) begin
            if (stall_left > 0) begin
                binReady = 1'b0;
                stall_left--;
            end else if (binValid && (accepted == v.stall_word) && !stall_done) begin
                stall_done = 1'b1;
                stall_left = v.stall_len - 1;
                binReady = 1'b0;
            end else begin
                binReady = ($urandom_range(99) < v.ready_pct);
            end
            busy_cycles++;
            tick();
            n++;
        end
        if (n >= 4000) check("run_budget", 1'b0, 1'b1);
        binReady = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("words", accepted, v.exp_words);
        check("valid_rises", valid_seen, v.exp_words);
        check("strobes", strobes, v.exp_strobes);
        check("error", error, v.exp_error != 0);
        check("end_busy", busy, 1'b0);
        check("end_valid", binValid, 1'b0);
        check("queue_empty", exp_q.size(), 0);
        if (v.exp_busy_cycles >= 0) check("timeout_cycles", busy_cycles, v.exp_busy_cycles);
    endtask

    initial begin
        int n;
        int s0;

        vecs[0] = '{100, -1,  0, 0, 2,  5, 0,   0, 32, 33, 0, -1};
        vecs[1] = '{100,  5, 10, 1, 3,  8, 0,   0, 32, 33, 0, -1};
        vecs[2] = '{ 50, -1,  0, 1, 0,  1, 0,   0, 32, 33, 0, -1};
        vecs[3] = '{100, -1,  0, 1, 2,  5, 1,   0,  0,  1, 1, TO + 1};
        vecs[4] = '{100, -1,  0, 1, 2,  4, 0, 100, 32, 33, 0, -1};
        vecs[5] = '{ 35, 31,  6, 1, 4, 12, 0,   0, 32, 33, 0, -1};

        sysResetN = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        binReady = 1'b0;
        clear_stats();
        hold_pending = 1'b0;
        prev_valid = 1'b0;
        load_reference(0);
        @(posedge sysClk);
        #1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_state", state, S_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_strobe", csrStrobe, 1'b0);
        check("rst_data", csrData, 32'h0);
        check("rst_valid", binValid, 1'b0);
        check("rst_last", binLast, 1'b0);
        sysResetN = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        for (int i = 0; i < 6; i++) run_acq(vecs[i]);

        // abort while word 7 is being offered
        load_reference(1);
        busy_delay = 2;
        busy_len = 5;
        no_busy = 1'b0;
        wrong_until = 0;
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(binValid && (accepted == 7)) && (n < 2000)) begin
            binReady = 1'b1;
            tick();
            n++;
        end
        if (n >= 2000) check("abort_budget", 1'b0, 1'b1);
        binReady = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", state, S_IDLE);
        check("abort_valid", binValid, 1'b0);
        check("abort_busy", busy, 1'b0);
        s0 = strobes;
        for (int i = 0; i < 20; i++) tick();
        check("abort_no_strobe", strobes, s0);
        check("abort_words", accepted, 7);
        run_acq(vecs[0]);

        // reset during WAIT_LO, with a start pulse while busy first
        busy_delay = 2;
        busy_len = 40;
        no_busy = 1'b0;
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while ((state != S_WAIT_LO) && (n < 200)) begin
            tick();
            n++;
        end
        if (n >= 200) check("wait_lo_budget", 1'b0, 1'b1);
        s0 = strobes;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_state", state, S_WAIT_LO);
        check("start_ignored_strobe", strobes, s0);
        sysResetN = 1'b0;
        tick();
        check("midrst_state", state, S_IDLE);
        check("midrst_busy", busy, 1'b0);
        check("midrst_error", error, 1'b0);
        check("midrst_data", csrData, 32'h0);
        check("midrst_valid", binValid, 1'b0);
        sysResetN = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        check("midrst_no_strobe", strobes, s0);
        check("midrst_idle", state, S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
